wb_lsu_bridge: RTL and testbench

Load/store bridge between the rv32i core's memory-stage bus and the Wishbone interconnect. It converts one core load or store per request into a single Wishbone classic cycle, handling byte lanes, sign extension and misalignment. It holds the pipeline stalled until the bus cycle terminates. It drives the interconnect's IO master port, which the interconnect decodes to DMEM, IMEM, UART, GPIO and SPI flash.

---
 rtl/wb_lsu_pkg.sv | 38 +++
 rtl/wb_lsu_align.sv | 65 ++++++
 rtl/wb_lsu_bridge.sv | 166 ++++++++++++++++
 tb/tb_wb_lsu_bridge.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_lsu_pkg                                                         |
// | Shared types for the rv32i load/store to Wishbone bridge.          |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package wb_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic size_t size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_of = SZ_B;
      2'b01:   size_of = SZ_H;
      2'b10:   size_of = SZ_W;
      default: size_of = SZ_X;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_lsu_align                                                       |
// | Byte-lane select, store replication, load extract/extend, legality.|
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module wb_lsu_align
  import wb_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  op,
  input  logic        write,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  sel,
  output logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        illegal
);

  size_t       w_size;
  logic        w_sign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_size     = size_of(op);
    w_sign     = ~op[2];
    sel        = 4'b1111;
    store_data = wdata;
    case (w_size)
      SZ_B: begin
        sel        = 4'b0001 << addr_lo;
        store_data = {4{wdata[7:0]}};
      end
      SZ_H: begin
        sel        = 4'b0011 << {addr_lo[1], 1'b0};
        store_data = {2{wdata[15:0]}};
      end
      default: ;
    endcase

    case (addr_lo)
      2'd0:    w_byte = bus_rdata[7:0];
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      default: w_byte = bus_rdata[31:24];
    endcase
    w_half = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    case (w_size)
      SZ_B:    load_data = {{24{w_sign & w_byte[7]}}, w_byte};
      SZ_H:    load_data = {{16{w_sign & w_half[15]}}, w_half};
      default: load_data = bus_rdata;
    endcase

    // Unsigned variants only exist for loads; misaligned H/W never reach the bus
    illegal = (op == 3'b011) || (op == 3'b110) || (op == 3'b111)
           || (write && ((op == F3_BU) || (op == F3_HU)))
           || ((w_size == SZ_H) && addr_lo[0])
           || ((w_size == SZ_W) && (addr_lo != 2'b00));
  end

endmodule
`default_nettype wire

// File: rtl/wb_lsu_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_lsu_bridge                                                      |
// | Core memory-stage load/store to one Wishbone classic cycle.        |
// | Optional bus timeout: define WB_LSU_TIMEOUT_EN.                    |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module wb_lsu_bridge
  import wb_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] proc_addr,
  input  logic [31:0] proc_wdata,
  input  logic        proc_write,
  input  logic        proc_read,
  input  logic [2:0]  proc_op,
  output logic [31:0] proc_rdata,
  output logic        proc_stall_pipl,
  output logic        proc_err,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_lane;
  logic [2:0]  r_op;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_req;
  logic [1:0]  w_lane;
  logic [2:0]  w_op;
  logic [3:0]  w_sel;
  logic [31:0] w_store_data;
  logic [31:0] w_load_data;
  logic        w_illegal;
  logic        w_timeout;
  logic        w_fault;
  logic        w_term;

  assign w_req   = proc_read | proc_write;
  // Decode from the live request while idle, from the latched one afterwards
  assign w_lane  = (r_state == S_IDLE) ? proc_addr[1:0] : r_lane;
  assign w_op    = (r_state == S_IDLE) ? proc_op : r_op;
  assign w_fault = wb_err_i | w_timeout;
  assign w_term  = wb_ack_i | w_fault;

  wb_lsu_align u_align (
    .addr_lo    (w_lane),
    .op         (w_op),
    .write      (proc_write),
    .wdata      (proc_wdata),
    .bus_rdata  (wb_dat_i),
    .sel        (w_sel),
    .store_data (w_store_data),
    .load_data  (w_load_data),
    .illegal    (w_illegal)
  );

`ifdef WB_LSU_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

  logic [CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_BUS) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th bus cycle, so cyc is high exactly that long
  assign w_timeout = (r_state == S_BUS) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    proc_stall_pipl = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          proc_stall_pipl = 1'b1;
          w_next          = w_illegal ? S_DONE : S_BUS;
        end
      end
      S_BUS: begin
        proc_stall_pipl = 1'b1;
        if (w_term) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign proc_err   = (r_state == S_DONE) & r_err;
  assign proc_rdata = r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane   <= 2'b00;
      r_op     <= 3'b000;
      r_err    <= 1'b0;
      r_rdata  <= 32'h0;
      wb_adr_o <= 32'h0;
      wb_dat_o <= 32'h0;
      wb_sel_o <= 4'h0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_req) begin
        r_lane <= proc_addr[1:0];
        r_op   <= proc_op;
        r_err  <= w_illegal;
        if (!w_illegal) begin
          wb_adr_o <= {proc_addr[31:2], 2'b00};
          wb_dat_o <= w_store_data;
          wb_sel_o <= w_sel;
          wb_we_o  <= proc_write;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
        end
      end else if ((r_state == S_BUS) && w_term) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        wb_we_o  <= 1'b0;
        wb_sel_o <= 4'h0;
        if (w_fault) begin
          r_err   <= 1'b1;
          r_rdata <= 32'h0;
        end else if (!wb_we_o) begin
          r_rdata <= w_load_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_lsu_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_wb_lsu_bridge                                                   |
// | Directed + random checks of wb_lsu_bridge against a behaviour model|
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_wb_lsu_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] proc_addr = '0;
  logic [31:0] proc_wdata = '0;
  logic        proc_write = 1'b0;
  logic        proc_read = 1'b0;
  logic [2:0]  proc_op = '0;
  logic [31:0] proc_rdata;
  logic        proc_stall_pipl;
  logic        proc_err;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_rdata = 32'h0;

  always #5 clk = ~clk;

  wb_lsu_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_write(proc_write),
    .proc_read(proc_read), .proc_op(proc_op), .proc_rdata(proc_rdata),
    .proc_stall_pipl(proc_stall_pipl), .proc_err(proc_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal(input logic [31:0] a, input logic [2:0] op, input bit wr);
    int sz = op % 4;
    if (op == 3 || op >= 6) return 0;
    if (wr && op >= 4) return 0;
    if (sz == 1 && (a % 2) != 0) return 0;
    if (sz == 2 && (a % 4) != 0) return 0;
    return 1;
  endfunction

  function automatic logic [3:0] m_sel(input logic [31:0] a, input logic [2:0] op);
    int sz = op % 4;
    if (sz == 0) return 4'(1 << (a % 4));
    if (sz == 1) return 4'(3 << ((a % 4) / 2 * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdat(input logic [31:0] d, input logic [2:0] op);
    int sz = op % 4;
    if (sz == 0) return (d % 256) * 32'h0101_0101;
    if (sz == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] op, input logic [31:0] rd);
    int sz = op % 4;
    logic [31:0] v;
    if (sz == 0) begin
      v = (rd >> (8 * (a % 4))) % 256;
      if (op < 4 && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = (rd >> (16 * ((a % 4) / 2))) % 65536;
      if (op < 4 && v >= 32768) v = v - 65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // resp: 0 ack, 1 err, 2 ack+err, 3 silent slave. Called just after a rising edge.
  task automatic run(input string nm, input logic [31:0] addr, input logic [2:0] op,
                     input bit rd, input bit wr, input logic [31:0] wdata,
                     input logic [31:0] rdat, input int nwait, input int resp);
    int stall_n = 0, cyc_n = 0;
    bit done = 0, err_early = 0, stb_bad = 0;
    logic c0cyc = 1'b0, d_err = 1'b0, d_cyc = 1'b0;
    logic [31:0] d_rdata = '0, f_adr = '0, f_dat = '0;
    logic [3:0] f_sel = '0;
    logic f_we = 1'b0;
    bit legal, is_load;
    int e_cyc;
    bit e_err;
    proc_addr = addr; proc_op = op; proc_read = rd; proc_write = wr; proc_wdata = wdata;
    legal   = m_legal(addr, op, wr);
    is_load = !wr;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (c == 0) c0cyc = wb_cyc_o;
      if (proc_stall_pipl) begin
        stall_n++;
        if (proc_err) err_early = 1;
        if (wb_cyc_o) begin
          cyc_n++;
          if (cyc_n == 1) begin
            f_adr = wb_adr_o; f_sel = wb_sel_o; f_dat = wb_dat_o; f_we = wb_we_o;
          end
          if (wb_stb_o !== 1'b1 || wb_we_o !== f_we || wb_adr_o !== f_adr) stb_bad = 1;
        end
        if (wb_cyc_o && resp != 3 && cyc_n > nwait) begin
          wb_ack_i = (resp != 1); wb_err_i = (resp != 0); wb_dat_i = rdat;
        end else begin
          wb_ack_i = 0; wb_err_i = 0; wb_dat_i = $urandom;
        end
      end else begin
        done = 1; d_err = proc_err; d_rdata = proc_rdata; d_cyc = wb_cyc_o;
        wb_ack_i = 0; wb_err_i = 0;
      end
    end
    if (!done) begin
      chk({nm, ":no_done"}, 32'(done), 32'd1);
      rst = 1; #1; rst = 0;
      return;
    end
    if (!legal) begin
      e_cyc = 0; e_err = 1;
    end else begin
      e_cyc = (resp == 3) ? TMO : nwait + 1;
      e_err = (resp != 0);
      if (e_err) exp_rdata = 32'h0;
      else if (is_load) exp_rdata = m_load(addr, op, rdat);
    end
    chk({nm, ":c0_cyc"}, 32'(c0cyc), 32'd0);
    chk({nm, ":stall_cycles"}, stall_n, (legal ? e_cyc + 1 : 1));
    chk({nm, ":cyc_cycles"}, cyc_n, e_cyc);
    chk({nm, ":err_early"}, 32'(err_early), 32'd0);
    chk({nm, ":done_err"}, 32'(d_err), 32'(e_err));
    chk({nm, ":done_cyc"}, 32'(d_cyc), 32'd0);
    chk({nm, ":rdata"}, d_rdata, exp_rdata);
    if (legal) begin
      chk({nm, ":adr"}, f_adr, addr & 32'hFFFF_FFFC);
      chk({nm, ":sel"}, 32'(f_sel), 32'(m_sel(addr, op)));
      chk({nm, ":we"}, 32'(f_we), 32'(wr));
      chk({nm, ":held"}, 32'(stb_bad), 32'd0);
      if (wr) chk({nm, ":wdat"}, f_dat, m_wdat(wdata, op));
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input string nm);
    proc_read = 0; proc_write = 0;
    @(negedge clk);
    chk({nm, ":idle_stall"}, 32'(proc_stall_pipl), 32'd0);
    chk({nm, ":idle_err"}, 32'(proc_err), 32'd0);
    chk({nm, ":idle_cyc"}, 32'(wb_cyc_o), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  rop;
    int k, r;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst:cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst:stb", 32'(wb_stb_o), 32'd0);
    chk("rst:we", 32'(wb_we_o), 32'd0);
    chk("rst:adr", wb_adr_o, 32'd0);
    chk("rst:sel", 32'(wb_sel_o), 32'd0);
    chk("rst:dat", wb_dat_o, 32'd0);
    chk("rst:rdata", proc_rdata, 32'd0);
    chk("rst:err", 32'(proc_err), 32'd0);
    chk("rst:stall", 32'(proc_stall_pipl), 32'd0);
    @(posedge clk); #1;

    run("lw104", 32'h0000_0104, 3'b010, 1, 0, 32'h0, 32'hDEAD_BEEF, 3, 0);
    chk("lw104:value", proc_rdata, 32'hDEAD_BEEF);
    idle("lw104");
    run("lb03", 32'h0000_1003, 3'b000, 1, 0, 32'h0, 32'h8000_0000, 0, 0);
    chk("lb03:value", proc_rdata, 32'hFFFF_FF80);
    run("lbu03", 32'h0000_1003, 3'b100, 1, 0, 32'h0, 32'h8000_0000, 1, 0);
    chk("lbu03:value", proc_rdata, 32'h0000_0080);
    idle("lbu03");
    run("sh02", 32'h0000_2002, 3'b001, 0, 1, 32'h1234_ABCD, 32'h5555_5555, 2, 0);
    chk("sh02:rdata_kept", proc_rdata, 32'h0000_0080);
    idle("sh02");
    run("lw01", 32'h0000_3001, 3'b010, 1, 0, 32'h0, 32'h0, 0, 0);
    idle("lw01");
    run("sw_ackerr", 32'h0000_4000, 3'b010, 0, 1, 32'hCAFE_F00D, 32'h0, 1, 2);
    run("b2b_lw", 32'h0000_4004, 3'b010, 1, 0, 32'h0, 32'h1357_9BDF, 0, 0);
    idle("b2b_lw");
    run("both_hi", 32'h0000_4005, 3'b000, 1, 1, 32'h0000_00A5, 32'h0, 0, 0);
    idle("both_hi");
`ifdef WB_LSU_TIMEOUT_EN
    run("timeout", 32'h0000_5000, 3'b010, 1, 0, 32'h0, 32'h0, 0, 3);
`else
    run("longwait", 32'h0000_5000, 3'b010, 1, 0, 32'h0, 32'h2468_ACE0, 40, 0);
`endif
    idle("longwait");

    // Reset pulse while a load is stuck on the bus
    proc_addr = 32'h0000_6000; proc_op = 3'b010; proc_read = 1; proc_write = 0;
    repeat (3) @(negedge clk);
    chk("midrst:pre_cyc", 32'(wb_cyc_o), 32'd1);
    #2; rst = 1; proc_read = 0;
    #1;
    chk("midrst:cyc", 32'(wb_cyc_o), 32'd0);
    chk("midrst:stb", 32'(wb_stb_o), 32'd0);
    chk("midrst:stall", 32'(proc_stall_pipl), 32'd0);
    @(negedge clk); rst = 0;
    exp_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst:err", 32'(proc_err), 32'd0);
      chk("midrst:cyc_after", 32'(wb_cyc_o), 32'd0);
    end
    chk("midrst:rdata", proc_rdata, 32'd0);
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      ra  = $urandom;
      rop = 3'($urandom_range(0, 7));
      k   = $urandom_range(1, 3);
      r   = $urandom_range(0, 9);
      if ($urandom_range(0, 2) != 0) begin
        ra  = ra & ~32'($urandom_range(0, 3));
        rop = (rop % 4 == 3) ? 3'b010 : rop;
      end
      run("rnd", ra, rop, k[0], k[1], $urandom, $urandom, $urandom_range(0, 5),
          (r < 7) ? 0 : ((r < 9) ? 1 : 2));
      if ($urandom_range(0, 1) == 1) idle("rnd");
    end
    idle("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
